// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter
// Round-robin arbiter that turns set/clear commands from NREQ requesters into
// registered one-hot set/clear pulses for a bank of NFLAG SR flip-flops. It
// keeps a shadow of the flag state and offers a sequenced clear-all sweep.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   req_valid  per-requester command valid
//   req_op     per-requester op at [2i+1:2i]: 00 nop, 01 clear, 10 set, 11 illegal
//   req_idx    per-requester flag index at [IDXW*i +: IDXW]
//   req_ready  one-hot grant (combinational)
//   clr_all    start a clear sweep (sampled only in IDLE)
//   flag_s     registered one-hot set pulse
//   flag_r     registered one-hot clear pulse
//   flags      shadow of the flag-bank state
//   busy       high while a sweep is in progress
//   err        one-cycle pulse after an accepted illegal command
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IDXW*NREQ-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 clr_all,
    output logic [NFLAG-1:0]     flag_s,
    output logic [NFLAG-1:0]     flag_r,
    output logic [NFLAG-1:0]     flags,
    output logic                 busy,
    output logic                 err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(NFLAG + 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t           state;
    logic [PW-1:0]    rr_ptr;
    logic [CW-1:0]    sweep_cnt;

    logic             grant_found;
    logic [PW-1:0]    grant;
    logic [1:0]       grant_op;
    logic [IDXW-1:0]  grant_idx;
    logic             idx_ok;
    logic [NFLAG-1:0] cmd_bit;

    function automatic logic [NFLAG-1:0] idx_bit(input logic [IDXW-1:0] idx);
        return NFLAG'(1) << idx;
    endfunction

    function automatic logic [NFLAG-1:0] cnt_bit(input logic [CW-1:0] cnt);
        return NFLAG'(1) << cnt;
    endfunction

    // Search upward from rr_ptr for the first valid requester. No grant while
    // in reset, during a sweep, or when clr_all wins the cycle.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        if (!reset && state == IDLE && !clr_all) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                    grant_found = 1'b1;
                    grant       = PW'((int'(rr_ptr) + k) % NREQ);
                end
            end
        end
    end

    assign req_ready = grant_found ? (NREQ'(1) << grant) : '0;
    assign grant_op  = req_op[2*grant +: 2];
    assign grant_idx = req_idx[IDXW*grant +: IDXW];
    assign idx_ok    = (int'(grant_idx) < NFLAG);
    assign cmd_bit   = idx_bit(grant_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            sweep_cnt <= '0;
            flag_s    <= '0;
            flag_r    <= '0;
            flags     <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-issued below.
            flag_s <= '0;
            flag_r <= '0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_all) begin
                        // Index 0 is issued on entry so it lines up with the
                        // first busy cycle; sweep_cnt then names the next index.
                        state     <= SWEEP;
                        busy      <= 1'b1;
                        flag_r    <= cnt_bit('0);
                        flags     <= flags & ~cnt_bit('0);
                        sweep_cnt <= CW'(1);
                    end else if (grant_found) begin
                        rr_ptr <= (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
                        if (grant_op == 2'b11 || !idx_ok) begin
                            err <= 1'b1;
                        end else if (grant_op == 2'b10) begin
                            flag_s <= cmd_bit;
                            flags  <= flags | cmd_bit;
                        end else if (grant_op == 2'b01) begin
                            flag_r <= cmd_bit;
                            flags  <= flags & ~cmd_bit;
                        end
                    end
                end
                SWEEP: begin
                    if (sweep_cnt == CW'(NFLAG)) begin
                        // Last index went out in the previous cycle.
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sweep_cnt <= '0;
                    end else begin
                        flag_r    <= cnt_bit(sweep_cnt);
                        flags     <= flags & ~cnt_bit(sweep_cnt);
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter
// Directed and randomised stimulus for sr_flag_arbiter (NREQ=4, NFLAG=8,
// IDXW=4 so that out-of-range indices such as 9 can be expressed).
module tb_sr_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IDXW  = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [2*NREQ-1:0]    req_op = '0;
    logic [IDXW*NREQ-1:0] req_idx = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 clr_all = 1'b0;
    logic [NFLAG-1:0]     flag_s;
    logic [NFLAG-1:0]     flag_r;
    logic [NFLAG-1:0]     flags;
    logic                 busy;
    logic                 err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .clr_all   (clr_all),
        .flag_s    (flag_s),
        .flag_r    (flag_r),
        .flags     (flags),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [IDXW-1:0] idx);
        req_valid[i]          = v;
        req_op[2*i +: 2]      = op;
        req_idx[IDXW*i +: IDXW] = idx;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    logic [7:0] mflags;
    logic [7:0] exp_s, exp_r, e8;
    logic       exp_err;
    int         r, v;
    logic [1:0] op;
    logic [3:0] idx;

    initial begin
        // Reset values
        #1;
        chk("rst_flag_s", flag_s, 0);
        chk("rst_flag_r", flag_r, 0);
        chk("rst_flags", flags, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        set_req(0, 1'b1, 2'b00, 4'd0);
        #1;
        chk("rst_ready", req_ready, 0);
        set_req(0, 1'b0, 2'b00, 4'd0);
        tick;
        reset = 1'b0;

        // Requester 0 sets idx 3
        set_req(0, 1'b1, 2'b10, 4'd3);
        #1;
        chk("set3_ready", req_ready, 4'b0001);
        tick;
        set_req(0, 1'b0, 2'b00, 4'd0);
        chk("set3_flag_s", flag_s, 8'h08);
        chk("set3_flag_r", flag_r, 8'h00);
        chk("set3_flags", flags, 8'h08);
        chk("set3_err", err, 0);

        // Full contention from rr_ptr=0: requester i sets idx i+4
        apply_reset;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b10, 4'(i + 4));
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", req_ready, 4'b0001 << (k % 4));
            tick;
            chk("rr_flag_s", flag_s, 8'h01 << ((k % 4) + 4));
        end
        req_valid = '0;
        chk("rr_flags", flags, 8'hF0);
        tick;
        chk("rr_idle_pulse", flag_s, 0);

        // Illegal op, then out-of-range index (rr_ptr is 1 here)
        set_req(2, 1'b1, 2'b11, 4'd1);
        #1;
        chk("ill_ready", req_ready, 4'b0100);
        tick;
        chk("ill_err", err, 1);
        chk("ill_flag_s", flag_s, 0);
        chk("ill_flag_r", flag_r, 0);
        chk("ill_flags", flags, 8'hF0);
        set_req(2, 1'b1, 2'b10, 4'd9);
        #1;
        chk("oor_ready", req_ready, 4'b0100);
        tick;
        chk("oor_err", err, 1);
        chk("oor_flag_s", flag_s, 0);
        chk("oor_flags", flags, 8'hF0);
        set_req(2, 1'b0, 2'b00, 4'd0);
        set_req(3, 1'b1, 2'b01, 4'd5);
        #1;
        chk("clr5_ready", req_ready, 4'b1000);
        tick;
        chk("clr5_err", err, 0);
        chk("clr5_flag_r", flag_r, 8'h20);
        chk("clr5_flags", flags, 8'hD0);
        set_req(3, 1'b0, 2'b00, 4'd0);
        // Clear of an already-clear flag still pulses
        set_req(1, 1'b1, 2'b01, 4'd0);
        #1;
        chk("clr0_ready", req_ready, 4'b0010);
        tick;
        chk("clr0_flag_r", flag_r, 8'h01);
        chk("clr0_flags", flags, 8'hD0);
        set_req(1, 1'b0, 2'b00, 4'd0);

        // Fill all flags, then sweep with requester 1 contending
        for (int i = 0; i < NFLAG; i++) begin
            set_req(0, 1'b1, 2'b10, 4'(i));
            tick;
        end
        set_req(0, 1'b0, 2'b00, 4'd0);
        chk("fill_flags", flags, 8'hFF);
        clr_all = 1'b1;
        set_req(1, 1'b1, 2'b10, 4'd2);
        #1;
        chk("sw_nogrant", req_ready, 0);
        chk("sw_busy_pre", busy, 0);
        tick;
        clr_all = 1'b0;
        for (int k = 0; k < NFLAG; k++) begin
            #1;
            e8 = 8'hFF << (k + 1);
            chk("sw_busy", busy, 1);
            chk("sw_flag_r", flag_r, 8'h01 << k);
            chk("sw_flag_s", flag_s, 0);
            chk("sw_flags", flags, e8);
            chk("sw_ready", req_ready, 0);
            tick;
        end
        chk("sw_end_busy", busy, 0);
        chk("sw_end_flag_r", flag_r, 0);
        chk("sw_end_flags", flags, 0);
        chk("sw_end_ready", req_ready, 4'b0010);
        tick;
        chk("sw_after_flag_s", flag_s, 8'h04);
        chk("sw_after_flags", flags, 8'h04);
        set_req(1, 1'b0, 2'b00, 4'd0);

        // Reset in sweep cycle 4
        set_req(0, 1'b1, 2'b10, 4'd7);
        tick;
        set_req(0, 1'b0, 2'b00, 4'd0);
        chk("pre_flags", flags, 8'h84);
        clr_all = 1'b1;
        tick;
        clr_all = 1'b0;
        tick;
        tick;
        tick;
        chk("ab_flag_r_c4", flag_r, 8'h08);
        chk("ab_flags_c4", flags, 8'h80);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b00, 4'd0);
        reset = 1'b1;
        #1;
        chk("ab_flag_r", flag_r, 0);
        chk("ab_busy", busy, 0);
        chk("ab_flags", flags, 0);
        chk("ab_ready", req_ready, 0);
        reset = 1'b0;
        #1;
        chk("ab_resume_ready", req_ready, 4'b0001);
        tick;
        chk("ab_resume_busy", busy, 0);
        chk("ab_resume_flag_r", flag_r, 0);
        req_valid = '0;

        // Random single-requester commands against a reference model
        mflags = 8'h00;
        for (int c = 0; c < 1000; c++) begin
            req_valid = '0;
            v   = int'($urandom_range(0, 3));
            r   = int'($urandom_range(0, NREQ - 1));
            op  = 2'($urandom_range(0, 3));
            idx = 4'($urandom_range(0, 15));
            if (v != 0) set_req(r, 1'b1, op, idx);
            #1;
            chk("rnd_ready", req_ready, (v != 0) ? (4'b0001 << r) : 4'b0000);
            exp_s = 8'h00;
            exp_r = 8'h00;
            exp_err = 1'b0;
            if (v != 0) begin
                if (op == 2'b11 || idx >= 4'(NFLAG)) begin
                    exp_err = 1'b1;
                end else if (op == 2'b10) begin
                    exp_s  = 8'h01 << idx;
                    mflags = mflags | exp_s;
                end else if (op == 2'b01) begin
                    exp_r  = 8'h01 << idx;
                    mflags = mflags & ~exp_r;
                end
            end
            tick;
            chk("rnd_flags", flags, mflags);
            chk("rnd_pulse", {flag_s, flag_r, err}, {exp_s, exp_r, exp_err});
            chk("rnd_excl", flag_s & flag_r, 0);
            chk("rnd_onehot", $onehot0(flag_s | flag_r), 1);
        end
        req_valid = '0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Arbitrated controller for a bank of SR flag flip-flops. Up to NREQ requesters issue set/clear commands against NFLAG flags; the block grants one command per cycle by round-robin and drives registered, mutually exclusive one-hot set/clear pulses to the flag bank. It never produces the illegal S=R=1 combination, keeps a shadow copy of the flag state, and provides a sequenced clear-all sweep.

## Interface
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of SR flags driven
- IDXW, 3, flag index width; must satisfy 2^IDXW >= NFLAG

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  per-requester command valid
- req_op  in  2*NREQ  per-requester op, requester i at [2i+1:2i]; 00 nop, 01 clear, 10 set, 11 illegal
- req_idx  in  IDXW*NREQ  per-requester flag index, requester i at [IDXW*i+IDXW-1:IDXW*i]
- req_ready  out  NREQ  one-hot grant; a command is accepted when req_valid[i] && req_ready[i]
- clr_all  in  1  request a full clear sweep (level sampled in IDLE)
- flag_s  out  NFLAG  registered one-hot set pulse to the flag bank
- flag_r  out  NFLAG  registered one-hot clear pulse to the flag bank
- flags  out  NFLAG  shadow of the flag-bank state
- busy  out  1  high while a sweep is in progress
- err  out  1  one-cycle pulse on an accepted illegal command

## Operation
- States: IDLE, SWEEP.
- IDLE, clr_all=0: grant the first requester with req_valid=1, searching upward from rr_ptr with wrap modulo NREQ. req_ready is combinational from req_valid, rr_ptr and state. Only the granted bit is high; all bits are 0 if no request is valid.
- On acceptance of requester g, rr_ptr <= (g+1) mod NREQ. rr_ptr does not change when nothing is granted.
- Accepted op 10 with idx<NFLAG: flag_s[idx]=1 and flags[idx]<=1 on the next cycle.
- Accepted op 01 with idx<NFLAG: flag_r[idx]=1 and flags[idx]<=0 on the next cycle.
- Accepted op 00: consumed. No pulse, no flag change, no error.
- Accepted op 11, or any op with idx>=NFLAG: consumed. No pulse and no flag change; err=1 for one cycle.
- Set on an already-set flag, or clear on an already-clear flag, still emits its pulse.
- IDLE, clr_all=1: no grant that cycle (clr_all has priority over requests); go to SWEEP with sweep_cnt=0.
- SWEEP: req_ready all 0; busy=1; clr_all ignored.
  - Each cycle emits flag_r one-hot at sweep_cnt and clears flags[sweep_cnt], then sweep_cnt increments.
  - After index NFLAG-1 the state returns to IDLE. Total sweep length is NFLAG cycles.
- Invariant on every cycle: (flag_s | flag_r) is zero or one-hot, and flag_s & flag_r == 0.

## Timing
- Reset values: state IDLE, rr_ptr 0, sweep_cnt 0, flag_s 0, flag_r 0, flags 0, busy 0, err 0, req_ready 0.
- Reset asserted mid-sweep aborts the sweep immediately; any pulse being emitted is dropped.
- Command latency: acceptance at edge N; flag_s/flag_r/err valid during cycle N+1; flags updated at edge N.
- Throughput: one accepted command per cycle in IDLE. A requester holding valid is granted at most once per NREQ cycles under full contention.
- busy is registered:
  - rises the cycle after clr_all is sampled;
  - the first sweep pulse (index 0) appears that same cycle;
  - falls after the cycle carrying index NFLAG-1;
  - grants resume that same cycle.
- Requesters must hold req_valid/op/idx stable until accepted.

## Test plan
- Reset, then requester 0 sets idx 3 -> next cycle flag_s=8'h08, flag_r=0, flags=8'h08, err=0.
- All 4 requesters valid continuously from rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles. No requester is granted twice within 4 cycles.
- Requester 2 issues op 11 idx 1, then op 10 idx 9 (NFLAG=8) -> both accepted; err pulses on each following cycle; flags unchanged; flag_s=flag_r=0.
- flags=8'hFF, clr_all=1 with requester 1 valid in the same cycle -> no grant. Then 8 cycles of busy=1 with flag_r = 01,02,04,...,80. flags reaches 0. Requester 1 is granted on the first cycle busy=0.
- Assert reset during sweep cycle 4 -> flag_r=0, busy=0, flags=0, req_ready=0 immediately. After release, normal grants resume from rr_ptr=0.
- Randomised mix of set/clear/illegal over 1000 cycles -> flags matches the reference model. flag_s & flag_r is never nonzero, and flag_s|flag_r is never multi-hot.
